// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the FIFO read-side controller: FSM state codes and FIFO depth.
package fifo_rd_ctrl_pkg;

  localparam int unsigned FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ISSUE = 3'b001,
    WAIT  = 3'b010,
    DRAIN = 3'b011,
    DONE  = 3'b100
  } state_t;

endpackage

// File: rtl/fifo_rd_ctrl_out.sv
// Decodes the controller state into busy/done status and the gated FIFO read request.
module fifo_rd_ctrl_out
  import fifo_rd_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   reset,
  input  logic   empty,
  input  logic   m_valid,
  input  logic   m_ready,
  output logic   busy,
  output logic   done,
  output logic   rd_en
);

  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    // Only read when the FIFO has data and the output slot is free or draining this cycle.
    rd_en = !reset && (state == ISSUE) && !empty && (!m_valid || m_ready);
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side burst initiator: pulls N words from the FIFO, retries on rd_err, streams them out.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  input  logic                  rd_ack,
  input  logic                  rd_err,
  input  logic [DATA_WIDTH-1:0] rd_dout,
  input  logic                  empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ERR_WIDTH-1:0]  err_cnt
);

  state_t               state;
  logic [LEN_WIDTH-1:0] remaining;

  fifo_rd_ctrl_out u_out (
    .state   (state),
    .reset   (reset),
    .empty   (empty),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      err_cnt   <= '0;
    end else begin
      if (m_valid && m_ready)
        m_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              remaining <= burst_len;
              state     <= ISSUE;
            end else begin
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          if (rd_en)
            state <= WAIT;
        end
        WAIT: begin
          // A missing response is treated like rd_err; rd_ack wins if both are set.
          if (rd_ack) begin
            m_data    <= rd_dout;
            m_valid   <= 1'b1;
            remaining <= remaining - LEN_WIDTH'(1);
            state     <= (remaining == LEN_WIDTH'(1)) ? DRAIN : ISSUE;
          end else begin
            if (err_cnt != '1)
              err_cnt <= err_cnt + ERR_WIDTH'(1);
            state <= ISSUE;
          end
        end
        DRAIN: begin
          if (m_valid && m_ready)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl with a small behavioural FIFO model.
module tb_fifo_rd_ctrl;
  import fifo_rd_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  burst_len = '0;
  logic        busy, done, rd_en;
  logic        rd_ack = 1'b0, rd_err = 1'b0;
  logic [31:0] rd_dout = '0;
  logic        empty;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  err_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.DATA_WIDTH(32), .LEN_WIDTH(4), .ERR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_ack(rd_ack), .rd_err(rd_err),
    .rd_dout(rd_dout), .empty(empty), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .err_cnt(err_cnt)
  );

  // FIFO model: responses arrive the cycle after rd_en; forced errors ignore occupancy.
  logic [31:0] mem [FIFO_DEPTH];
  int unsigned wp = 0, rp = 0, cnt = 0;
  int unsigned errs_given = 0, force_target = 0;
  logic        push_req = 1'b0;
  logic [31:0] push_data = '0;
  logic        pop;

  assign empty = (cnt == 0);
  assign pop   = rd_en && (errs_given >= force_target) && (cnt != 0);

  always @(posedge clk) begin
    rd_ack <= 1'b0;
    rd_err <= 1'b0;
    if (rd_en) begin
      if (errs_given < force_target) begin
        rd_err     <= 1'b1;
        errs_given <= errs_given + 1;
      end else if (cnt != 0) begin
        rd_ack  <= 1'b1;
        rd_dout <= mem[rp];
        rp      <= (rp + 1) % FIFO_DEPTH;
      end else begin
        rd_err <= 1'b1;
      end
    end
    if (push_req) begin
      mem[wp] <= push_data;
      wp      <= (wp + 1) % FIFO_DEPTH;
    end
    cnt <= cnt + (push_req ? 1 : 0) - (pop ? 1 : 0);
  end

  // Stream / request monitor.
  logic [31:0] got [$];
  int unsigned n_rd = 0, n_b2b = 0, n_done = 0, n_bad = 0;
  logic        prev_rd = 1'b0;

  always @(posedge clk) begin
    if (m_valid && m_ready && !reset) got.push_back(m_data);
    if (rd_en) n_rd <= n_rd + 1;
    if (rd_en && prev_rd) n_b2b <= n_b2b + 1;
    if (rd_en && empty) n_bad <= n_bad + 1;
    if (done) n_done <= n_done + 1;
    prev_rd <= rd_en;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    push_req  = 1'b1;
    push_data = d;
    @(negedge clk);
    push_req  = 1'b0;
  endtask

  task automatic start_burst(input logic [3:0] len);
    start     = 1'b1;
    burst_len = len;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned snap);
    int unsigned k = 0;
    while (n_done == snap && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(n_done - snap), 64'd1);
  endtask

  int unsigned g0, r0, d0, b0, e0;
  int unsigned bad_data, bad_rd, k;
  logic [31:0] exp_words [4];

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);

    // Burst of 4 from a preloaded FIFO.
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    g0 = got.size(); r0 = n_rd; d0 = n_done; b0 = n_b2b;
    start_burst(4'd4);
    check("t1_first_rd_en", 64'(rd_en), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_wait_no_rd", 64'(rd_en), 64'd0);
    @(negedge clk);
    check("t1_first_valid", 64'(m_valid), 64'd1);
    check("t1_first_data", 64'(m_data), 64'hA0);
    wait_done("t1_done", d0);
    check("t1_busy_idle", 64'(busy), 64'd0);
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_rd_count", 64'(n_rd - r0), 64'd4);
    check("t1_alternate", 64'(n_b2b - b0), 64'd0);
    check("t1_words", 64'(got.size() - g0), 64'd4);
    for (int i = 0; i < 4; i++)
      if (got.size() > g0 + i) check("t1_word", 64'(got[g0 + i]), 64'hA0 + 64'(i));
    check("t1_err_cnt", 64'(err_cnt), 64'd0);

    // Burst of 2 from an initially empty FIFO.
    g0 = got.size(); r0 = n_rd; d0 = n_done; b0 = n_bad;
    start_burst(4'd2);
    repeat (10) @(negedge clk);
    check("t2_no_rd_empty", 64'(n_rd - r0), 64'd0);
    check("t2_busy_waiting", 64'(busy), 64'd1);
    push(32'h11);
    repeat (10) @(negedge clk);
    check("t2_one_word", 64'(got.size() - g0), 64'd1);
    check("t2_not_done_yet", 64'(n_done - d0), 64'd0);
    push(32'h22);
    wait_done("t2_done", d0);
    check("t2_words", 64'(got.size() - g0), 64'd2);
    if (got.size() >= g0 + 2) begin
      check("t2_word0", 64'(got[g0]), 64'h11);
      check("t2_word1", 64'(got[g0 + 1]), 64'h22);
    end
    check("t2_rd_while_empty", 64'(n_bad - b0), 64'd0);

    // Three forced read errors, then the single word completes.
    push(32'h33);
    g0 = got.size(); r0 = n_rd; d0 = n_done;
    force_target = errs_given + 3;
    start_burst(4'd1);
    wait_done("t3_done", d0);
    check("t3_err_cnt", 64'(err_cnt), 64'd3);
    check("t3_rd_count", 64'(n_rd - r0), 64'd4);
    check("t3_words", 64'(got.size() - g0), 64'd1);
    if (got.size() > g0) check("t3_word", 64'(got[g0]), 64'h33);

    // Consumer stall after the first word.
    for (int i = 0; i < 3; i++) push(32'hA0 + 32'(i));
    m_ready = 1'b0;
    g0 = got.size(); d0 = n_done;
    start_burst(4'd3);
    k = 0;
    while (!m_valid && k < 50) begin @(negedge clk); k++; end
    check("t4_valid_seen", 64'(m_valid), 64'd1);
    bad_data = 0; bad_rd = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_data !== 32'hA0 || !m_valid) bad_data++;
      if (rd_en) bad_rd++;
      @(negedge clk);
    end
    check("t4_data_stable", 64'(bad_data), 64'd0);
    check("t4_no_rd_full", 64'(bad_rd), 64'd0);
    m_ready = 1'b1;
    wait_done("t4_done", d0);
    exp_words[0] = 32'hA0; exp_words[1] = 32'hA1; exp_words[2] = 32'hA2;
    check("t4_words", 64'(got.size() - g0), 64'd3);
    for (int i = 0; i < 3; i++)
      if (got.size() > g0 + i) check("t4_word", 64'(got[g0 + i]), 64'(exp_words[i]));

    // Zero-length burst.
    r0 = n_rd;
    start_burst(4'd0);
    check("t5_done", 64'(done), 64'd1);
    check("t5_no_rd", 64'(rd_en), 64'd0);
    @(negedge clk);
    check("t5_done_one_cycle", 64'(done), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_no_valid", 64'(m_valid), 64'd0);
    check("t5_rd_count", 64'(n_rd - r0), 64'd0);

    // Reset while a read is outstanding.
    push(32'h55);
    push(32'h66);
    start_burst(4'd2);
    k = 0;
    while (!rd_en && k < 50) begin @(negedge clk); k++; end
    check("t6_issue_seen", 64'(rd_en), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_m_valid", 64'(m_valid), 64'd0);
    check("t6_m_data", 64'(m_data), 64'd0);
    check("t6_err_cnt", 64'(err_cnt), 64'd0);
    check("t6_rd_en", 64'(rd_en), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    g0 = got.size(); d0 = n_done;
    start_burst(4'd1);
    wait_done("t6_fresh_done", d0);
    check("t6_fresh_words", 64'(got.size() - g0), 64'd1);
    if (got.size() > g0) check("t6_fresh_word", 64'(got[g0]), 64'h66);
    check("t6_fresh_err_cnt", 64'(err_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
